watchdog_timer: RTL and testbench
=================================

WATCHDOG_TIMER -- requirements
Module: watchdog

Interface
REQ-001 SHALL have parameter DFL_TIMEOUT, default 8'h03, meaning the reset value of the TIMEOUT register and of the down-counter, in wdt_ce ticks.
REQ-002 SHALL have port clk, input, 1 bit: single system clock; all state changes on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit: reset; one clock, reset is asynchronous and active-high.
REQ-004 SHALL have port csr_a, input, 5 bits: register address.
REQ-005 SHALL have port csr_di, input, 8 bits: write data.
REQ-006 SHALL have port csr_we, input, 1 bit: write strobe, sampled on the clk edge.
REQ-007 SHALL have port csr_do, output, 8 bits: read data, combinational from csr_a.
REQ-008 SHALL have port wdt_ce, input, 1 bit: one-clk-wide tick enable; the counter advances only when it is high.
REQ-009 SHALL have port wdt_sys_rst, output, 1 bit: system reset request.
REQ-010 SHALL have port wdt_timeout, output, 1 bit: watchdog-timeout indication.

Function
REQ-011 SHALL have a register map: 0x00 CTRL; 0x01 TIMEOUT (8-bit reload value); 0x02 KICK (write-only, reads 0x00); 0x03 COUNT (read-only current counter); all other addresses read 0x00 and ignore writes.
REQ-012 SHALL define CTRL bits as: bit0 EN; bit2 LOCK; bit6 ASSERT_SYS_RESET; bit7 ASSERT_WDT_TIMEOUT; bits 1, 3-5 reserved, read 0, writes ignored.
REQ-013 SHALL make a CTRL or TIMEOUT write take effect on the clk edge where csr_we=1; readback SHALL show the new value from the next cycle.
REQ-014 SHALL, once LOCK=1, ignore all writes to CTRL and TIMEOUT until rst; KICK SHALL still work.
REQ-015 SHALL load COUNT with TIMEOUT and clear the expired flag on a write of 0x6B to KICK; writes of any other value to KICK SHALL be ignored.
REQ-016 SHALL load COUNT with TIMEOUT (the new value, if written in the same cycle) on a CTRL write that changes EN from 0 to 1.
REQ-017 SHALL, on each clock with EN=1 and wdt_ce=1 and no valid kick: decrement COUNT if COUNT>1; if COUNT<=1, set COUNT to 0 and set the sticky expired flag.
REQ-018 SHALL leave COUNT frozen at 0 while expired; COUNT SHALL not wrap.
REQ-019 SHALL give a valid kick priority when it coincides with a tick: COUNT is reloaded and no decrement occurs.
REQ-020 SHALL, while EN=0, hold COUNT and clear the expired flag.
REQ-021 SHALL drive wdt_sys_rst = expired AND ASSERT_SYS_RESET, and wdt_timeout = expired AND ASSERT_WDT_TIMEOUT, both registered with a level held until kick, disable or rst.
REQ-022 SHALL, with TIMEOUT=0, make the first tick after enable cause expiry.
REQ-023 SHALL deliver expiry N ticks after load, where N = TIMEOUT; outputs rise on the clk edge of the N-th tick.

Reset
REQ-024 SHALL, on rst: CTRL=0x00, TIMEOUT=DFL_TIMEOUT, COUNT=DFL_TIMEOUT, expired=0, wdt_sys_rst=0, wdt_timeout=0.
REQ-025 SHALL, on rst asserted mid-count or while expired, return all state to reset values immediately, asynchronously, and SHALL clear LOCK.

Verification
REQ-026 SHALL verify: after reset, read 0x00 -> 0x00; read 0x01 -> 0x03; read 0x03 -> 0x03 (DFL_TIMEOUT=3).
REQ-027 SHALL verify: write 0x41 to CTRL with wdt_ce pulsing every 64 clk -> COUNT reads 3, 2, 1, 0 across ticks; wdt_sys_rst=1 on the 3rd tick; wdt_timeout stays 0.
REQ-028 SHALL verify: enabled with COUNT=1, write 0x6B to KICK -> COUNT=3, no expiry; a write of 0x00 to KICK leaves COUNT unchanged.
REQ-029 SHALL verify: write 0x85 (EN, LOCK, ASSERT_WDT_TIMEOUT), then write 0x00 to CTRL and 0x10 to TIMEOUT -> CTRL stays 0x85, TIMEOUT stays 0x03, and wdt_timeout asserts after 3 ticks.
REQ-030 SHALL verify: a kick and wdt_ce in the same cycle -> COUNT equals TIMEOUT, not TIMEOUT-1.
REQ-031 SHALL verify: rst pulse while wdt_sys_rst=1 -> outputs 0 at once, CTRL=0x00, COUNT=0x03.

Source files
------------

// File: rtl/watchdog_timer.sv
// watchdog_timer
// ---------------------------------------------------------------------------
// CSR-programmed watchdog. Software arms the timer by setting EN in CTRL,
// then must write the magic key 0x6B to KICK before TIMEOUT wdt_ce ticks
// elapse. If it does not, a sticky expired flag is set. That flag is turned
// into a system-reset request and/or a timeout indication, depending on the
// assert bits in CTRL. Setting LOCK freezes CTRL and TIMEOUT until reset.
//
// Register map (csr_a):
//   0x00 CTRL    : bit0 EN, bit2 LOCK, bit6 ASSERT_SYS_RESET,
//                  bit7 ASSERT_WDT_TIMEOUT; other bits read 0
//   0x01 TIMEOUT : reload value for the down-counter
//   0x02 KICK    : write-only, 0x6B reloads the counter, reads 0x00
//   0x03 COUNT   : read-only current counter value
//   others       : read 0x00, writes ignored
//
// Ports:
//   clk         - system clock, all state changes on its rising edge
//   rst         - asynchronous active-high reset
//   csr_a       - register address
//   csr_di      - write data
//   csr_we      - write strobe, sampled on the clk edge
//   csr_do      - read data, combinational from csr_a
//   wdt_ce      - one-clk-wide tick enable for the down-counter
//   wdt_sys_rst - registered system reset request
//   wdt_timeout - registered watchdog-timeout indication
// ---------------------------------------------------------------------------
module watchdog_timer #(
  parameter logic [7:0] DFL_TIMEOUT = 8'h03
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [4:0] csr_a,
  input  logic [7:0] csr_di,
  input  logic       csr_we,
  output logic [7:0] csr_do,
  input  logic       wdt_ce,
  output logic       wdt_sys_rst,
  output logic       wdt_timeout
);

  localparam logic [4:0] ADDR_CTRL    = 5'h00;
  localparam logic [4:0] ADDR_TIMEOUT = 5'h01;
  localparam logic [4:0] ADDR_KICK    = 5'h02;
  localparam logic [4:0] ADDR_COUNT   = 5'h03;

  // Only the implemented CTRL bits are stored; reserved bits stay 0.
  localparam logic [7:0] CTRL_MASK = 8'hC5;
  localparam logic [7:0] KICK_KEY  = 8'h6B;

  localparam int EN_BIT      = 0;
  localparam int LOCK_BIT    = 2;
  localparam int SYSRST_BIT  = 6;
  localparam int TIMEOUT_BIT = 7;

  logic [7:0] r_ctrl;
  logic [7:0] r_timeout;
  logic [7:0] r_count;
  logic       r_expired;
  logic       r_sys_rst;
  logic       r_wdt_timeout;

  logic       w_locked;
  logic       w_ctrl_wr;
  logic       w_timeout_wr;
  logic       w_kick;
  logic       w_en_rise;
  logic [7:0] w_ctrl_nxt;
  logic [7:0] w_timeout_nxt;
  logic [7:0] w_count_nxt;
  logic       w_expired_nxt;

  // LOCK is checked against the stored value, so the write that sets LOCK
  // still lands, and every CTRL/TIMEOUT write after it is dropped.
  assign w_locked      = r_ctrl[LOCK_BIT];
  assign w_ctrl_wr     = csr_we && (csr_a == ADDR_CTRL) && !w_locked;
  assign w_timeout_wr  = csr_we && (csr_a == ADDR_TIMEOUT) && !w_locked;
  assign w_kick        = csr_we && (csr_a == ADDR_KICK) && (csr_di == KICK_KEY);
  assign w_ctrl_nxt    = w_ctrl_wr ? (csr_di & CTRL_MASK) : r_ctrl;
  assign w_timeout_nxt = w_timeout_wr ? csr_di : r_timeout;
  assign w_en_rise     = !r_ctrl[EN_BIT] && w_ctrl_nxt[EN_BIT];

  // Counter and expired flag. Priority order:
  //   1. kick or enable edge  - reload from TIMEOUT, clear expired
  //   2. disabled             - hold count, clear expired
  //   3. tick                 - count down; reaching the bottom expires
  // Once expired, the count is 0 and the tick branch keeps it at 0, so
  // the counter never wraps.
  always_comb begin
    w_count_nxt   = r_count;
    w_expired_nxt = r_expired;
    if (w_kick || w_en_rise) begin
      w_count_nxt   = w_timeout_nxt;
      w_expired_nxt = 1'b0;
    end else if (!w_ctrl_nxt[EN_BIT]) begin
      w_expired_nxt = 1'b0;
    end else if (wdt_ce) begin
      if (r_count > 8'd1) begin
        w_count_nxt = r_count - 8'd1;
      end else begin
        w_count_nxt   = 8'd0;
        w_expired_nxt = 1'b1;
      end
    end
  end

  // State registers. The outputs are registered from the next-state values.
  // This makes them rise on the same edge that sets the expired flag, and
  // drop on the edge of a kick or disable.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ctrl        <= 8'h00;
      r_timeout     <= DFL_TIMEOUT;
      r_count       <= DFL_TIMEOUT;
      r_expired     <= 1'b0;
      r_sys_rst     <= 1'b0;
      r_wdt_timeout <= 1'b0;
    end else begin
      r_ctrl        <= w_ctrl_nxt;
      r_timeout     <= w_timeout_nxt;
      r_count       <= w_count_nxt;
      r_expired     <= w_expired_nxt;
      r_sys_rst     <= w_expired_nxt && w_ctrl_nxt[SYSRST_BIT];
      r_wdt_timeout <= w_expired_nxt && w_ctrl_nxt[TIMEOUT_BIT];
    end
  end

  // Read mux. KICK and unmapped addresses read back as zero.
  always_comb begin
    csr_do = 8'h00;
    case (csr_a)
      ADDR_CTRL:    csr_do = r_ctrl;
      ADDR_TIMEOUT: csr_do = r_timeout;
      ADDR_COUNT:   csr_do = r_count;
      default:      csr_do = 8'h00;
    endcase
  end

  assign wdt_sys_rst = r_sys_rst;
  assign wdt_timeout = r_wdt_timeout;

endmodule

// File: tb/tb_watchdog_timer.sv
// tb_watchdog_timer
// ---------------------------------------------------------------------------
// Self-checking bench for watchdog_timer. It runs directed scenarios with
// fixed expected values first. A randomized CSR/tick sequence follows, and
// it is checked every cycle against a register-level reference model.
// ---------------------------------------------------------------------------
module tb_watchdog_timer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [4:0] csr_a = 5'd0;
  logic [7:0] csr_di = 8'd0;
  logic       csr_we = 1'b0;
  logic [7:0] csr_do;
  logic       wdt_ce = 1'b0;
  logic       wdt_sys_rst;
  logic       wdt_timeout;

  int vectors = 0;
  int miscompares = 0;

  // Reference model state: programmer-visible registers plus the expiry flag.
  logic [7:0] mCtrl;
  logic [7:0] mTimeout;
  logic [7:0] mCount;
  logic       mExpired;

  watchdog_timer #(.DFL_TIMEOUT(8'h03)) dut (
    .clk(clk),
    .rst(rst),
    .csr_a(csr_a),
    .csr_di(csr_di),
    .csr_we(csr_we),
    .csr_do(csr_do),
    .wdt_ce(wdt_ce),
    .wdt_sys_rst(wdt_sys_rst),
    .wdt_timeout(wdt_timeout)
  );

  always #5 clk = ~clk;

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [7:0] observed, input logic [7:0] expected);
    vectors++;
    if (observed !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: observed 0x%02h expected 0x%02h at %0t", tag, observed, expected, $time);
    end
  endtask

  function automatic void modelReset();
    mCtrl    = 8'h00;
    mTimeout = 8'h03;
    mCount   = 8'h03;
    mExpired = 1'b0;
  endfunction

  function automatic logic [7:0] modelRead(input logic [4:0] a);
    case (a)
      5'h00:   return mCtrl;
      5'h01:   return mTimeout;
      5'h03:   return mCount;
      default: return 8'h00;
    endcase
  endfunction

  // The watchdog behaviour is described in terms of what software sees.
  // Locked registers ignore writes. A key kick or a fresh enable restarts
  // the countdown. Disabling forgets any expiry. Each tick while armed uses
  // up one unit of the remaining budget, and the bottom of the countdown is
  // sticky.
  function automatic void modelStep(input logic [4:0] a, input logic [7:0] di,
                                    input logic we, input logic ce);
    logic [7:0] nCtrl;
    logic [7:0] nTimeout;
    logic       kick;
    logic       armedBefore;
    armedBefore = mCtrl[0];
    nCtrl       = mCtrl;
    nTimeout    = mTimeout;
    if (we && !mCtrl[2] && a == 5'h00) nCtrl = di & 8'hC5;
    if (we && !mCtrl[2] && a == 5'h01) nTimeout = di;
    kick = we && (a == 5'h02) && (di == 8'h6B);
    if (kick || (!armedBefore && nCtrl[0])) begin
      mCount   = nTimeout;
      mExpired = 1'b0;
    end else if (!nCtrl[0]) begin
      mExpired = 1'b0;
    end else if (ce) begin
      if (mCount > 8'd1) begin
        mCount = mCount - 8'd1;
      end else begin
        mCount   = 8'd0;
        mExpired = 1'b1;
      end
    end
    mCtrl    = nCtrl;
    mTimeout = nTimeout;
  endfunction

  // Drives one clock cycle of inputs. Before the edge it checks the read
  // data and the outputs against the model, then it advances the model.
  task automatic applyStimulus(input logic [4:0] a, input logic [7:0] di,
                               input logic we, input logic ce);
    csr_a  = a;
    csr_di = di;
    csr_we = we;
    wdt_ce = ce;
    #2;
    checkOutput("model_csr_do", csr_do, modelRead(a));
    checkOutput("model_sys_rst", {7'd0, wdt_sys_rst}, {7'd0, mExpired & mCtrl[6]});
    checkOutput("model_timeout", {7'd0, wdt_timeout}, {7'd0, mExpired & mCtrl[7]});
    @(posedge clk);
    modelStep(a, di, we, ce);
    #1;
    csr_we = 1'b0;
    wdt_ce = 1'b0;
  endtask

  task automatic expectRead(input string tag, input logic [4:0] a, input logic [7:0] exp);
    csr_a  = a;
    csr_we = 1'b0;
    #1;
    checkOutput(tag, csr_do, exp);
  endtask

  task automatic expectPins(input string tag, input logic sysRst, input logic tmo);
    #1;
    checkOutput({tag, "_sys_rst"}, {7'd0, wdt_sys_rst}, {7'd0, sysRst});
    checkOutput({tag, "_timeout"}, {7'd0, wdt_timeout}, {7'd0, tmo});
  endtask

  task automatic doReset();
    csr_we = 1'b0;
    wdt_ce = 1'b0;
    rst    = 1'b1;
    modelReset();
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic idleCycles(input int n);
    for (int i = 0; i < n; i++) applyStimulus(5'h03, 8'h00, 1'b0, 1'b0);
  endtask

  initial begin
    modelReset();
    doReset();

    // Reset values.
    expectRead("rst_ctrl", 5'h00, 8'h00);
    expectRead("rst_timeout", 5'h01, 8'h03);
    expectRead("rst_count", 5'h03, 8'h03);
    expectRead("rst_kick_reads0", 5'h02, 8'h00);
    expectPins("rst_pins", 1'b0, 1'b0);

    // Enable with the system-reset assert bit, using a tick every 64 clocks.
    applyStimulus(5'h00, 8'h41, 1'b1, 1'b0);
    expectRead("en_ctrl", 5'h00, 8'h41);
    expectRead("en_count", 5'h03, 8'h03);
    for (int k = 1; k <= 3; k++) begin
      idleCycles(63);
      applyStimulus(5'h03, 8'h00, 1'b0, 1'b1);
      expectRead($sformatf("tick%0d_count", k), 5'h03, 8'(3 - k));
      expectPins($sformatf("tick%0d", k), (k == 3), 1'b0);
    end
    applyStimulus(5'h03, 8'h00, 1'b0, 1'b1);
    expectRead("expired_no_wrap", 5'h03, 8'h00);
    expectPins("expired_held", 1'b1, 1'b0);
    // Disabling drops the request; the count stays frozen.
    applyStimulus(5'h00, 8'h40, 1'b1, 1'b0);
    expectPins("disable_clears", 1'b0, 1'b0);
    expectRead("disable_holds_count", 5'h03, 8'h00);

    // Kick handling: a bad key is ignored, the good key reloads.
    doReset();
    applyStimulus(5'h00, 8'hC1, 1'b1, 1'b0);
    applyStimulus(5'h03, 8'h00, 1'b0, 1'b1);
    applyStimulus(5'h03, 8'h00, 1'b0, 1'b1);
    expectRead("pre_kick_count", 5'h03, 8'h01);
    applyStimulus(5'h02, 8'h00, 1'b1, 1'b0);
    expectRead("bad_kick_count", 5'h03, 8'h01);
    applyStimulus(5'h02, 8'h6B, 1'b1, 1'b0);
    expectRead("good_kick_count", 5'h03, 8'h03);
    expectPins("good_kick", 1'b0, 1'b0);

    // A kick coinciding with a tick wins: reload, no decrement.
    doReset();
    applyStimulus(5'h01, 8'h05, 1'b1, 1'b0);
    applyStimulus(5'h00, 8'h01, 1'b1, 1'b0);
    applyStimulus(5'h03, 8'h00, 1'b0, 1'b1);
    expectRead("pre_kicktick_count", 5'h03, 8'h04);
    applyStimulus(5'h02, 8'h6B, 1'b1, 1'b1);
    expectRead("kick_tick_count", 5'h03, 8'h05);

    // LOCK freezes CTRL and TIMEOUT but not the countdown.
    doReset();
    applyStimulus(5'h00, 8'h85, 1'b1, 1'b0);
    applyStimulus(5'h00, 8'h00, 1'b1, 1'b0);
    applyStimulus(5'h01, 8'h10, 1'b1, 1'b0);
    expectRead("lock_ctrl", 5'h00, 8'h85);
    expectRead("lock_timeout", 5'h01, 8'h03);
    for (int k = 1; k <= 3; k++) begin
      applyStimulus(5'h03, 8'h00, 1'b0, 1'b1);
      expectPins($sformatf("lock_tick%0d", k), 1'b0, (k == 3));
    end

    // TIMEOUT=0 expires on the first tick after enable.
    doReset();
    applyStimulus(5'h01, 8'h00, 1'b1, 1'b0);
    applyStimulus(5'h00, 8'hC1, 1'b1, 1'b0);
    expectRead("to0_count", 5'h03, 8'h00);
    expectPins("to0_before_tick", 1'b0, 1'b0);
    applyStimulus(5'h03, 8'h00, 1'b0, 1'b1);
    expectPins("to0_first_tick", 1'b1, 1'b1);

    // An asynchronous reset while expired clears everything at once.
    doReset();
    applyStimulus(5'h00, 8'h41, 1'b1, 1'b0);
    for (int k = 0; k < 3; k++) applyStimulus(5'h03, 8'h00, 1'b0, 1'b1);
    expectPins("pre_async_rst", 1'b1, 1'b0);
    #2;
    rst = 1'b1;
    modelReset();
    expectPins("async_rst", 1'b0, 1'b0);
    expectRead("async_rst_ctrl", 5'h00, 8'h00);
    expectRead("async_rst_count", 5'h03, 8'h03);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Randomized traffic against the model, with occasional resets.
    for (int i = 0; i < 3000; i++) begin
      logic [4:0] a;
      logic [7:0] di;
      logic       we;
      logic       ce;
      if ($urandom_range(0, 399) == 0) doReset();
      a  = ($urandom_range(0, 9) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 3));
      di = ($urandom_range(0, 3) == 0) ? 8'h6B : 8'($urandom_range(0, 255));
      // Keep LOCK rare so most of the run exercises reprogramming.
      if (a == 5'h00 && $urandom_range(0, 7) != 0) di[2] = 1'b0;
      we = ($urandom_range(0, 9) < 3);
      ce = ($urandom_range(0, 3) == 0);
      applyStimulus(a, di, we, ce);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
